// File: rtl/prog_mod_counter.sv
// ============================================================================
// Module      : prog_mod_counter
// Description : Programmable modulus up/down counter with one-shot halt,
//               terminal pulse and divide-by-2M toggle output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_mod_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] modulus_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             one_shot_i,
  output logic [WIDTH-1:0] state_o,
  output logic             terminal_o,
  output logic             div_o,
  output logic             halted_o
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e           fsm_q, fsm_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mreg_q, mreg_d;
  logic             term_q, term_d;
  logic             div_q, div_d;

  logic [WIDTH-1:0] w_meff, w_meff_in, w_top, w_top_in;
  logic             w_run, w_tc;

  // Moduli of 0 and 1 both collapse to divide-by-1 (count pinned at 0).
  assign w_meff    = (mreg_q    < 2) ? C_ONE : mreg_q;
  assign w_meff_in = (modulus_i < 2) ? C_ONE : modulus_i;
  assign w_top     = w_meff    - C_ONE;
  assign w_top_in  = w_meff_in - C_ONE;

  assign w_run = (fsm_q == ST_RUN);
  assign w_tc  = enable_i & w_run & ~load_i &
                 (dir_i ? (count_q == '0) : (count_q == w_top));

  always_comb begin
    fsm_d   = fsm_q;
    count_d = count_q;
    mreg_d  = mreg_q;
    term_d  = 1'b0;
    div_d   = div_q;
    if (load_i) begin
      mreg_d  = modulus_i;
      count_d = (load_value_i > w_top_in) ? w_top_in : load_value_i;
      fsm_d   = ST_RUN;
    end else if (w_tc) begin
      // Wrap target uses the modulus being captured on this same edge.
      mreg_d  = modulus_i;
      count_d = dir_i ? w_top_in : '0;
      div_d   = ~div_q;
      term_d  = 1'b1;
      if (one_shot_i) begin
        fsm_d = ST_HALT;
      end
    end else if (enable_i && w_run) begin
      count_d = dir_i ? (count_q - C_ONE) : (count_q + C_ONE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= ST_RUN;
      count_q <= '0;
      mreg_q  <= modulus_i;
      term_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      count_q <= count_d;
      mreg_q  <= mreg_d;
      term_q  <= term_d;
      div_q   <= div_d;
    end
  end

  assign state_o    = count_q;
  assign terminal_o = term_q;
  assign div_o      = div_q;
  assign halted_o   = (fsm_q == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_prog_mod_counter.sv
// ============================================================================
// Module      : tb_prog_mod_counter
// Description : Directed self-checking bench for prog_mod_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_mod_counter;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, enable, dir, load, one_shot;
  logic [WIDTH-1:0] modulus, load_value;
  logic [WIDTH-1:0] state_o;
  logic             terminal_o, div_o, halted_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  prog_mod_counter #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .modulus_i    (modulus),
    .dir_i        (dir),
    .load_i       (load),
    .load_value_i (load_value),
    .one_shot_i   (one_shot),
    .state_o      (state_o),
    .terminal_o   (terminal_o),
    .div_o        (div_o),
    .halted_o     (halted_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int s, input int t, input int d, input int h);
    check({tag, ".state"},  16'(state_o),    16'(s));
    check({tag, ".term"},   16'(terminal_o), 16'(t));
    check({tag, ".div"},    16'(div_o),      16'(d));
    check({tag, ".halted"}, 16'(halted_o),   16'(h));
  endtask

  // Expected (state, terminal, div) after each enabled edge.
  int up5_s[10]  = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
  int up5_t[10]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int up5_d[10]  = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
  int dn_s[10]   = '{5, 4, 3, 2, 1, 0, 2, 1, 0, 2};
  int dn_t[10]   = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 1};
  int dn_d[10]   = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1};

  initial begin
    rst = 1'b1; enable = 1'b0; dir = 1'b0; load = 1'b0; one_shot = 1'b0;
    modulus = 8'd5; load_value = '0;

    // Reset state, then free-running up count with M=5
    step();
    check_all("reset", 0, 0, 0, 0);
    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_all($sformatf("up5[%0d]", i), up5_s[i], up5_t[i], up5_d[i], 0);
    end

    // Down count M=6, modulus changed to 3 mid-sequence at count 3
    rst = 1'b1; modulus = 8'd6; dir = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_all($sformatf("down[%0d]", i), dn_s[i], dn_t[i], dn_d[i], 0);
      if (i == 2) modulus = 8'd3;
    end

    // Load clamp with M=4: loadValue 9 -> 3, no pulse, div held
    rst = 1'b1; modulus = 8'd4; dir = 1'b0;
    step();
    rst = 1'b0;
    step();
    check_all("ld.pre1", 1, 0, 0, 0);
    step();
    check_all("ld.pre2", 2, 0, 0, 0);
    load = 1'b1; load_value = 8'd9;
    step();
    check_all("ld.clamp", 3, 0, 0, 0);
    load = 1'b0;
    step();
    check_all("ld.wrap", 0, 1, 1, 0);

    // One-shot with M=3
    rst = 1'b1; modulus = 8'd3; one_shot = 1'b1;
    step();
    rst = 1'b0;
    step(); check_all("os.c1", 1, 0, 0, 0);
    step(); check_all("os.c2", 2, 0, 0, 0);
    step(); check_all("os.wrap", 0, 1, 1, 1);
    step(); check_all("os.hold1", 0, 0, 1, 1);
    step(); check_all("os.hold2", 0, 0, 1, 1);
    load = 1'b1; load_value = 8'd1;
    step(); check_all("os.load", 1, 0, 1, 0);
    load = 1'b0;
    step(); check_all("os.c2b", 2, 0, 1, 0);
    step(); check_all("os.wrap2", 0, 1, 0, 1);
    one_shot = 1'b0;
    step(); check_all("os.stay", 0, 0, 0, 1);

    // Degenerate modulus 0, then enable low for 3 cycles
    rst = 1'b1; modulus = 8'd0;
    step();
    rst = 1'b0;
    step(); check_all("m0.e1", 0, 1, 1, 0);
    step(); check_all("m0.e2", 0, 1, 0, 0);
    step(); check_all("m0.e3", 0, 1, 1, 0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("m0.hold[%0d]", i), 0, 0, 1, 0);
    end
    enable = 1'b1;
    step(); check_all("m0.resume", 0, 1, 0, 0);

    // Reset with simultaneous load at count 4, div high
    rst = 1'b1; modulus = 8'd5;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check_all("rl.pre", 4, 0, 1, 0);
    rst = 1'b1; load = 1'b1; load_value = 8'd2;
    step();
    check_all("rl.post", 0, 0, 0, 0);
    rst = 1'b0; load = 1'b0;

    // Reset while halted
    one_shot = 1'b1; modulus = 8'd2;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); check_all("rh.c1", 1, 0, 0, 0);
    step(); check_all("rh.halt", 0, 1, 1, 1);
    rst = 1'b1;
    step(); check_all("rh.reset", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_mod_counter.md
PROG_MOD_COUNTER -- requirements
Module: prog_mod_counter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the count, modulus and load value; legal range 2..16.
REQ-002 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
REQ-005 enable  input  1  count advance qualifier; when low, all state holds.
REQ-006 modulus  input  WIDTH  requested modulus M; captured into a shadow register per REQ-010.
REQ-007 dir  input  1  0 = count up, 1 = count down.
REQ-008 load  input  1  synchronous load strobe, one cycle.
REQ-009 loadValue  input  WIDTH  value written to the count on load.
REQ-009a oneShot  input  1  0 = free-running wrap, 1 = halt after first terminal event.
REQ-009b stateOut  output  WIDTH  current registered count.
REQ-009c terminalOut  output  1  registered one-cycle terminal pulse.
REQ-009d divOut  output  1  registered toggle output; frequency is the enabled-cycle rate divided by 2M.
REQ-009e halted  output  1  high while in the HALT state.

Function
REQ-010 The shadow modulus mReg SHALL be loaded from modulus during reset, on every wrap, and on every load; mid-sequence changes to modulus SHALL have no effect until then.
REQ-011 Effective modulus SHALL be Meff = max(mReg, 1); mReg = 0 or 1 means divide-by-1, with count held at 0.
REQ-012 Terminal condition tc SHALL be: enable & RUN & !load & (dir=0 ? count==Meff-1 : count==0).
REQ-013 Up count: on an enabled cycle, count SHALL advance by +1; when tc is true, count SHALL wrap to 0.
REQ-014 Down count: on an enabled cycle, count SHALL advance by -1; when tc is true, count SHALL wrap to Meff-1 (using the newly captured mReg).
REQ-015 dir changes SHALL take effect on the next enabled cycle; no state is reset by a dir change.
REQ-016 terminalOut SHALL be high for exactly the one cycle after each cycle in which tc is true (latency 1), and low otherwise.
REQ-017 divOut SHALL toggle on the edge where tc is true.
REQ-018 Load SHALL have priority over enable.
REQ-018a Load SHALL write min(loadValue, Meff'-1) to the count, where Meff' is derived from the modulus input sampled in the same cycle.
REQ-018b Load SHALL NOT generate tc and SHALL NOT toggle divOut.
REQ-019 The FSM SHALL have two states, RUN and HALT; reset SHALL enter RUN.
REQ-020 RUN->HALT: when tc is true and oneShot=1. In HALT the count SHALL hold at the wrapped value, and tc, terminalOut and divOut SHALL stay inactive or held.
REQ-021 HALT->RUN: on load only; changing oneShot to 0 SHALL NOT leave HALT.
REQ-022 halted SHALL be registered and equal (state==HALT).
REQ-023 With enable low, count, divOut and FSM SHALL hold, and terminalOut SHALL be 0 on the next cycle.
REQ-024 Count SHALL never leave the range 0..Meff-1. All arithmetic SHALL be WIDTH bits, with no dependence on overflow.

Reset
REQ-025 Reset SHALL have priority over load and enable.
REQ-026 Reset SHALL force: stateOut=0, terminalOut=0, divOut=0, halted=0, FSM=RUN, mReg=modulus.
REQ-027 Reset asserted mid-count or in HALT SHALL produce the values of REQ-026 on the following edge, with no terminal pulse.

Verification
REQ-028 Free-run up: M=5, dir=0, enable=1 -> stateOut 0,1,2,3,4,0...; terminalOut high the cycle after each 4; divOut period 10 cycles.
REQ-029 Down plus modulus change: M=6, dir=1; at count=3 set modulus=3 -> continues 2,1,0, then wraps to 2; sequence 2,1,0 repeats.
REQ-030 Load clamp: M=4, load=1 with loadValue=9 -> stateOut=3, no terminalOut pulse, divOut unchanged.
REQ-031 One-shot: M=3, oneShot=1, up -> 0,1,2,0 then holds at 0; halted=1; one terminalOut pulse; load of 1 -> RUN, counts 1,2,0, then halts again.
REQ-032 Degenerate/hold: M=0 -> stateOut=0, terminalOut high every enabled cycle, divOut toggles every enabled cycle; enable low for 3 cycles -> all outputs hold, terminalOut=0.
REQ-033 Reset mid-operation: reset asserted at count=4 with load=1 in the same cycle -> next cycle all outputs 0 and FSM=RUN.
